fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC, drives the
//   instruction memory address, and loads the IF/ID pipeline register that feeds decode.
//   Handles stall (load-use hold), branch redirect with IF/ID flush, and halt detection.
//   Instruction memory read is combinational; all state updates on posedge clock.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   HALT_WORD  32'hFFFF_FFFF  instruction encoding that stops fetch
//   COUNT_W    32             width of statistics counters
// PORTS
//   clock             in   1   one clock; all registers update on posedge
//   reset             in   1   asynchronous, active-low; clears all state while 0
//   imem_address      out  32  byte address to instruction memory; always equals pc
//   imem_instruction  in   32  instruction read combinationally at imem_address
//   stall             in   1   hold PC and IF/ID (from hazard detection)
//   branch_taken      in   1   redirect fetch and flush IF/ID
//   branch_target     in   32  redirect address; bits [1:0] ignored
//   if_id_instruction out  32  IF/ID instruction; 0 (nop) when bubble
//   if_id_pc_four     out  32  IF/ID PC+4 of that instruction; 0 when bubble
//   if_id_valid       out  1   IF/ID holds a real instruction
//   halted            out  1   1 while the FSM is in HALTED
//   fetch_count       out  COUNT_W  instructions loaded into IF/ID (see CONFIGURATION)
//   stall_count       out  COUNT_W  cycles in RUN with stall=1 and branch_taken=0
// BEHAVIOUR
//   Reset (reset==0, async): pc=RESET_PC with [1:0] forced 00; if_id_*=0; state=BOOT;
//     halted=0; counters=0. Reset asserted mid-operation discards all in-flight state immediately.
//   Bubble = {if_id_instruction=0, if_id_pc_four=0, if_id_valid=0}.
//   FSM states BOOT, RUN, HALTED; priority per edge is branch_taken > stall > normal.
//   BOOT: lasts exactly 1 cycle; pc held; IF/ID stays bubble; goes to RUN. Inputs ignored.
//   RUN, branch_taken=1: pc<={branch_target[31:2],2'b00}; IF/ID<=bubble. Overrides stall.
//   RUN, stall=1 (no branch): pc and IF/ID hold their values.
//   RUN, normal, imem_instruction!=HALT_WORD: IF/ID<={imem_instruction, pc+4, 1};
//     pc<=pc+4. Latency is 1 cycle from imem_address to if_id_instruction.
//   RUN, normal, imem_instruction==HALT_WORD: IF/ID<=bubble; pc held; state<=HALTED.
//   HALTED: pc held; IF/ID bubble; stall ignored. branch_taken=1 sets pc to the target,
//     keeps IF/ID as bubble, and returns to RUN (an older in-flight branch cancels the halt).
//   Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
//   halted is a registered state decode, not a combinational function of the inputs.
// CONFIGURATION
//   FETCH_STATS_EN defined: fetch_count increments on each edge that loads IF/ID with
//     valid=1. stall_count increments on each RUN edge with stall=1 and branch_taken=0.
//     Both counters saturate at all-ones and clear only on reset.
//   FETCH_STATS_EN undefined: no counter registers; fetch_count and stall_count are tied
//     to 0. Port list is identical in both builds.
// TESTING
//   1 reset release, RESET_PC=0, mem[0]=A,mem[4]=B -> BOOT 1 cycle (valid=0), then
//     IF/ID=A/pc_four 4, next B/8; imem_address 0,0,4,8
//   2 stall=1 for 3 cycles while IF/ID=B -> pc and IF/ID frozen 3 cycles; stall_count=3
//     (with FETCH_STATS_EN)
//   3 stall=1 and branch_taken=1, target=32'h40 on the same edge -> pc=32'h40; IF/ID=bubble;
//     next fetch from 32'h40
//   4 mem[8]=HALT_WORD -> IF/ID bubble, halted=1, pc stays 8 indefinitely; then
//     branch_taken target 32'h10 -> halted=0, fetch resumes at 32'h10
//   5 pc=32'hFFFF_FFFC normal fetch -> pc wraps to 0; branch target 32'h13 -> pc=32'h10
//   6 reset pulsed low mid-run between clock edges -> outputs cleared immediately
//     (no edge needed); BOOT repeats after release

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, imem address, IF/ID register
//
// Owns the program counter, presents it to a combinational instruction memory
// and loads the IF/ID pipeline register that feeds decode. Handles load-use
// stall, branch redirect with IF/ID flush, and halt detection on HALT_WORD.
//
// Optional feature macro: FETCH_STATS_EN (fetch/stall statistics counters).
//
// Ports:
//   clock              in   1        all registers update on posedge
//   reset              in   1        asynchronous, active-low
//   imem_address       out  32       byte address to instruction memory (== pc)
//   imem_instruction   in   32       instruction read at imem_address
//   stall              in   1        hold pc and IF/ID
//   branch_taken       in   1        redirect fetch, flush IF/ID
//   branch_target      in   32       redirect address, bits [1:0] ignored
//   if_id_instruction  out  32       IF/ID instruction, 0 when bubble
//   if_id_pc_four      out  32       IF/ID pc+4, 0 when bubble
//   if_id_valid        out  1        IF/ID holds a real instruction
//   halted             out  1        fetch is stopped on HALT_WORD
//   fetch_count        out  COUNT_W  valid loads into IF/ID (stats build only)
//   stall_count        out  COUNT_W  RUN cycles stalled without branch (stats build only)

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter int          COUNT_W   = 32
) (
   input  logic               clock,
   input  logic               reset,
   output logic [31:0]        imem_address,
   input  logic [31:0]        imem_instruction,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   output logic [31:0]        if_id_instruction,
   output logic [31:0]        if_id_pc_four,
   output logic               if_id_valid,
   output logic               halted,
   output logic [COUNT_W-1:0] fetch_count,
   output logic [COUNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] instr_d;
   logic [31:0] pc_four_d;
   logic        valid_d;
   logic [31:0] target_aligned;
   logic        unused_target_bits;

   assign target_aligned     = {branch_target[31:2], 2'b00};
   assign unused_target_bits = ^branch_target[1:0];
   assign imem_address       = pc;
   // Decode of the registered state only; no input reaches this output.
   assign halted             = (state == HALTED);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= BOOT;
         pc                <= RESET_PC_ALIGNED;
         if_id_instruction <= 32'h0;
         if_id_pc_four     <= 32'h0;
         if_id_valid       <= 1'b0;
      end else begin
         state             <= state_d;
         pc                <= pc_d;
         if_id_instruction <= instr_d;
         if_id_pc_four     <= pc_four_d;
         if_id_valid       <= valid_d;
      end
   end

   always_comb begin
      // Default: hold everything (the stall behaviour).
      state_d   = state;
      pc_d      = pc;
      instr_d   = if_id_instruction;
      pc_four_d = if_id_pc_four;
      valid_d   = if_id_valid;
      case (state)
         BOOT: begin
            // One settling cycle with the memory addressed at RESET_PC.
            state_d   = RUN;
            instr_d   = 32'h0;
            pc_four_d = 32'h0;
            valid_d   = 1'b0;
         end
         RUN: begin
            if (branch_taken) begin
               pc_d      = target_aligned;
               instr_d   = 32'h0;
               pc_four_d = 32'h0;
               valid_d   = 1'b0;
            end else if (!stall) begin
               if (imem_instruction == HALT_WORD) begin
                  state_d   = HALTED;
                  instr_d   = 32'h0;
                  pc_four_d = 32'h0;
                  valid_d   = 1'b0;
               end else begin
                  instr_d   = imem_instruction;
                  pc_four_d = pc + 32'd4;
                  valid_d   = 1'b1;
                  pc_d      = pc + 32'd4;
               end
            end
         end
         HALTED: begin
            // A branch resolved behind the halt word was older, so it wins.
            instr_d   = 32'h0;
            pc_four_d = 32'h0;
            valid_d   = 1'b0;
            if (branch_taken) begin
               pc_d    = target_aligned;
               state_d = RUN;
            end
         end
         default: begin
            state_d   = BOOT;
            instr_d   = 32'h0;
            pc_four_d = 32'h0;
            valid_d   = 1'b0;
         end
      endcase
   end

`ifdef FETCH_STATS_EN
   logic               fetch_inc;
   logic               stall_inc;
   logic [COUNT_W-1:0] fetch_q;
   logic [COUNT_W-1:0] stall_q;

   assign fetch_inc = (state == RUN) && !branch_taken && !stall &&
                      (imem_instruction != HALT_WORD);
   assign stall_inc = (state == RUN) && !branch_taken && stall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_q <= '0;
         stall_q <= '0;
      end else begin
         if (fetch_inc && (fetch_q != '1)) fetch_q <= fetch_q + 1'b1;
         if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
   end

   assign fetch_count = fetch_q;
   assign stall_count = stall_q;
`else
   assign fetch_count = '0;
   assign stall_count = '0;
`endif

endmodule
